// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I access sizes and the
// request-tracking state encoding.
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_WAIT = 1'b1
    } lsu_state_e;

    // Size/alignment/direction combinations that must never reach memory.
    function automatic logic lsu_illegal(input logic [2:0] size,
                                         input logic       we,
                                         input logic [1:0] ofs);
        logic bad;
        bad = 1'b0;
        case (size)
            LDST_B:  bad = 1'b0;
            LDST_H:  bad = ofs[0];
            LDST_W:  bad = (ofs != 2'b00);
            LDST_BU: bad = we;
            LDST_HU: bad = we | ofs[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Selects the addressed byte/half of a memory read word and sign- or
// zero-extends it according to the RV32I load size.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  size,
    input  logic [1:0]  ofs,
    output logic [31:0] data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        sel_b = rdata[7:0];
        case (ofs)
            2'd0: sel_b = rdata[7:0];
            2'd1: sel_b = rdata[15:8];
            2'd2: sel_b = rdata[23:16];
            2'd3: sel_b = rdata[31:24];
            default: sel_b = rdata[7:0];
        endcase
        sel_h = ofs[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            LDST_B:  data = {{24{sel_b[7]}}, sel_b};
            LDST_BU: data = {24'd0, sel_b};
            LDST_H:  data = {{16{sel_h[15]}}, sel_h};
            LDST_HU: data = {16'd0, sel_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit initiator: converts core load/store requests into aligned
// memory transactions, stalls until memory is ready and returns load data.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_rvalid_o,
    output logic              core_stall_o,
    output logic              core_misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    input  logic              mem_ready_i
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("lsu_mem_initiator: DATA_W must be 32");
    end

    lsu_state_e        state_q, state_d;
    logic              busy_q;
    logic [1:0]        ofs;
    logic              illegal;
    logic [DATA_W-1:0] ext_data;

    assign busy_q = (state_q == LSU_WAIT);
    assign ofs    = core_addr_i[1:0];

    assign mem_addr_o = {core_addr_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        case (core_size_i)
            LDST_B:  mem_wd_o = {4{core_wd_i[7:0]}};
            LDST_H:  mem_wd_o = {2{core_wd_i[15:0]}};
            default: mem_wd_o = core_wd_i;
        endcase
    end

    lsu_load_ext u_load_ext (
        .rdata (mem_rd_i),
        .size  (core_size_i),
        .ofs   (ofs),
        .data  (ext_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_be_o        = '0;
        core_stall_o    = 1'b0;
        core_misalign_o = 1'b0;
        illegal         = lsu_illegal(core_size_i, core_we_i, ofs);

        if (core_req_i) begin
            if (illegal) begin
                core_misalign_o = 1'b1;
            end else begin
                mem_req_o    = 1'b1;
                mem_we_o     = core_we_i;
                core_stall_o = ~(busy_q & mem_ready_i);
                if (!core_we_i) begin
                    mem_be_o = 4'b1111;
                end else begin
                    case (core_size_i)
                        LDST_B:  mem_be_o = 4'b0001 << ofs;
                        LDST_H:  mem_be_o = 4'b0011 << ofs;
                        default: mem_be_o = 4'b1111;
                    endcase
                end
            end
        end

        // The access is outstanding exactly while the core is being stalled.
        state_d       = core_stall_o ? LSU_WAIT : LSU_IDLE;
        core_rvalid_o = busy_q & mem_ready_i & ~core_we_i;
        core_rd_o     = core_rvalid_o ? ext_data : '0;
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed self-checking bench for lsu_mem_initiator; load results are
// checked through a scoreboard queue popped by an independent monitor.
module tb_lsu_mem_initiator;
    import lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_rvalid_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    logic        done = 1'b0;

    always #5 clk_i = ~clk_i;

    lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .core_req_i      (core_req_i),
        .core_we_i       (core_we_i),
        .core_size_i     (core_size_i),
        .core_addr_i     (core_addr_i),
        .core_wd_i       (core_wd_i),
        .core_rd_o       (core_rd_o),
        .core_rvalid_o   (core_rvalid_o),
        .core_stall_o    (core_stall_o),
        .core_misalign_o (core_misalign_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wd_o        (mem_wd_o),
        .mem_rd_i        (mem_rd_i),
        .mem_ready_i     (mem_ready_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every load completion must match the oldest expected value.
    always @(negedge clk_i) begin
        logic [31:0] e;
        if (!done) begin
            if (core_rvalid_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("load_data", core_rd_o, e);
                end
            end else begin
                chk("rd_zero_no_rvalid", core_rd_o, 32'd0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic access(input string nm, input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int delay, input logic early,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
        int stalls;
        stalls      = 0;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_rd_i    = rdata;
        if (!we) sb_q.push_back(exp_rd);
        for (int c = 0; c <= delay + 1; c++) begin
            mem_ready_i = (c == delay + 1) || early;
            @(negedge clk_i);
            if (core_stall_o === 1'b1) stalls++;
            chk({nm, "_stall"}, 32'(core_stall_o), 32'(c != delay + 1));
            chk({nm, "_be"}, 32'(mem_be_o), 32'(exp_be));
            if (c == 0) begin
                chk({nm, "_mem_req"}, 32'(mem_req_o), 32'd1);
                chk({nm, "_mem_we"}, 32'(mem_we_o), 32'(we));
                chk({nm, "_misalign"}, 32'(core_misalign_o), 32'd0);
                chk({nm, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
                if (we) chk({nm, "_wd"}, mem_wd_o, exp_wd);
            end
            next_cycle();
        end
        chk({nm, "_stall_cycles"}, 32'(stalls), 32'(delay + 1));
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    task automatic bad_req(input string nm, input logic we, input logic [2:0] size,
                           input logic [31:0] addr);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        chk({nm, "_misalign"}, 32'(core_misalign_o), 32'd1);
        chk({nm, "_mem_req"}, 32'(mem_req_o), 32'd0);
        chk({nm, "_stall"}, 32'(core_stall_o), 32'd0);
        chk({nm, "_be"}, 32'(mem_be_o), 32'd0);
        next_cycle();
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = LDST_W;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;
        next_cycle();
        @(negedge clk_i);
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_misalign", 32'(core_misalign_o), 32'd0);
        chk("rst_rvalid", 32'(core_rvalid_o), 32'd0);
        next_cycle();
        rst_i = 1'b0;

        // Memory ready while idle must not produce a completion.
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ready_rvalid", 32'(core_rvalid_o), 32'd0);
        next_cycle();
        mem_ready_i = 1'b0;

        access("lw",   1'b0, LDST_W,  32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF);
        access("lb",   1'b0, LDST_B,  32'h103, 32'h0, 32'h80123456, 0, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80);
        access("lbu",  1'b0, LDST_BU, 32'h103, 32'h0, 32'h80123456, 0, 1'b0, 4'hF, 32'h0, 32'h00000080);
        access("lhu",  1'b0, LDST_HU, 32'h102, 32'h0, 32'h80123456, 0, 1'b0, 4'hF, 32'h0, 32'h00008012);
        access("lh0",  1'b0, LDST_H,  32'h100, 32'h0, 32'h1234F00D, 1, 1'b0, 4'hF, 32'h0, 32'hFFFFF00D);
        access("lh2",  1'b0, LDST_H,  32'h102, 32'h0, 32'hFFFE0000, 0, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFE);
        access("lb1",  1'b0, LDST_B,  32'h101, 32'h0, 32'h00007F00, 0, 1'b0, 4'hF, 32'h0, 32'h0000007F);
        access("lbu2", 1'b0, LDST_BU, 32'h102, 32'h0, 32'h00C30000, 0, 1'b0, 4'hF, 32'h0, 32'h000000C3);
        access("sb",   1'b1, LDST_B,  32'h101, 32'h000000A5, 32'h0, 1, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        access("sb3",  1'b1, LDST_B,  32'h103, 32'hFFFFFF3C, 32'h0, 0, 1'b0, 4'b1000, 32'h3C3C3C3C, 32'h0);
        access("sh",   1'b1, LDST_H,  32'h102, 32'h1234BEEF, 32'h0, 3, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0);
        access("sw",   1'b1, LDST_W,  32'h104, 32'h12345678, 32'h0, 0, 1'b0, 4'hF, 32'h12345678, 32'h0);

        // Back-to-back with ready held high: new access still needs two cycles.
        access("b2b0", 1'b0, LDST_W,  32'h108, 32'h0, 32'h11111111, 0, 1'b1, 4'hF, 32'h0, 32'h11111111);
        access("b2b1", 1'b0, LDST_W,  32'h10C, 32'h0, 32'h22222222, 0, 1'b1, 4'hF, 32'h0, 32'h22222222);

        bad_req("lw_mis", 1'b0, LDST_W,  32'h102);
        bad_req("lh_mis", 1'b0, LDST_H,  32'h101);
        bad_req("st_sz4", 1'b1, LDST_BU, 32'h100);
        bad_req("st_sz5", 1'b1, LDST_HU, 32'h100);
        bad_req("ld_sz3", 1'b0, 3'd3,    32'h100);
        access("post_bad", 1'b0, LDST_W, 32'h110, 32'h0, 32'h33333333, 0, 1'b1, 4'hF, 32'h0, 32'h33333333);

        // Reset while an access is outstanding.
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = LDST_W;
        core_addr_i = 32'h200;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rstw_first_stall", 32'(core_stall_o), 32'd1);
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rstw_during_rvalid", 32'(core_rvalid_o), 32'd0);
        next_cycle();
        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rstw_after_rvalid", 32'(core_rvalid_o), 32'd0);
        chk("rstw_after_stall", 32'(core_stall_o), 32'd0);
        next_cycle();
        mem_ready_i = 1'b0;
        access("post_rst", 1'b0, LDST_W, 32'h204, 32'h0, 32'hCAFEF00D, 0, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D);

        next_cycle();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
